// File: rtl/fp_pkg.sv
// Shared FP datapath definitions, reused by the FP regfile, the FPU and the write-back buffer.
package fp_pkg;

    localparam int FP_DATA_WIDTH = 32;
    localparam int FP_ADDR_WIDTH = 5;
    localparam int FP_WB_DEPTH   = 4;

    typedef struct packed {
        logic [FP_ADDR_WIDTH-1:0] rd;
        logic [FP_DATA_WIDTH-1:0] data;
    } fp_entry_t;

endpackage

// File: rtl/fp_wb_fwd_match.sv
// Youngest-match forwarding lookup for one regfile read port over the queued entries.
module fp_wb_fwd_match
    import fp_pkg::*;
#(
    parameter int DATA_WIDTH = FP_DATA_WIDTH,
    parameter int ADDR_WIDTH = FP_ADDR_WIDTH,
    parameter int DEPTH      = FP_WB_DEPTH
) (
    input  logic [DEPTH-1:0][ADDR_WIDTH-1:0] ent_rd_i,
    input  logic [DEPTH-1:0][DATA_WIDTH-1:0] ent_data_i,
    input  logic [$clog2(DEPTH)-1:0]         head_i,
    input  logic [$clog2(DEPTH):0]           count_i,
    input  logic [ADDR_WIDTH-1:0]            addr_i,
    output logic                             hit_o,
    output logic [DATA_WIDTH-1:0]            data_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0] idx_s;

    // Walk oldest to youngest so that a later (younger) match overrides an earlier one.
    always_comb begin
        hit_o  = 1'b0;
        data_o = '0;
        idx_s  = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx_s = head_i + PW'(k);
            if ((CW'(k) < count_i) && (addr_i != '0) && (ent_rd_i[idx_s] == addr_i)) begin
                hit_o  = 1'b1;
                data_o = ent_data_i[idx_s];
            end else begin
                hit_o  = hit_o;
                data_o = data_o;
            end
        end
    end

endmodule

// File: rtl/fp_wb_buffer.sv
// In-order FP result write-back queue with regfile drain, forwarding and busy-register scoreboard.
module fp_wb_buffer
    import fp_pkg::*;
#(
    parameter int DATA_WIDTH = FP_DATA_WIDTH,
    parameter int ADDR_WIDTH = FP_ADDR_WIDTH,
    parameter int DEPTH      = FP_WB_DEPTH
) (
    input  logic                       Clk,
    input  logic                       Rst_n,
    input  logic                       In_Valid,
    output logic                       In_Ready,
    input  logic [ADDR_WIDTH-1:0]      In_Rd,
    input  logic [DATA_WIDTH-1:0]      In_Data,
    input  logic                       Flush,
    input  logic                       Drain_En,
    output logic                       RF_WE,
    output logic [ADDR_WIDTH-1:0]      RF_W,
    output logic [DATA_WIDTH-1:0]      RF_Din,
    input  logic [ADDR_WIDTH-1:0]      Addr1,
    input  logic [ADDR_WIDTH-1:0]      Addr2,
    output logic                       Fwd1_Hit,
    output logic                       Fwd2_Hit,
    output logic [DATA_WIDTH-1:0]      Fwd1_Data,
    output logic [DATA_WIDTH-1:0]      Fwd2_Data,
    output logic [2**ADDR_WIDTH-1:0]   Busy,
    output logic [$clog2(DEPTH):0]     Count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0]                    head_q, head_d;
    logic [PW-1:0]                    tail_q, tail_d;
    logic [CW-1:0]                    count_q, count_d;
    logic [DEPTH-1:0][ADDR_WIDTH-1:0] rd_q, rd_d;
    logic [DEPTH-1:0][DATA_WIDTH-1:0] data_q, data_d;

    logic                             ready_s;
    logic                             empty_s;
    logic                             push_s;
    logic                             pop_s;
    logic [PW-1:0]                    busy_idx_s;
    logic [2**ADDR_WIDTH-1:0]         busy_s;

    assign ready_s = (count_q != CW'(DEPTH));
    assign empty_s = (count_q == '0);
    // Results for f0 complete the handshake but never occupy a slot.
    assign push_s  = In_Valid && ready_s && !Flush && (In_Rd != '0);
    assign pop_s   = !empty_s && Drain_En && !Flush;

    // Next-state for pointers, occupancy and entry storage; Flush overrides push and pop.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        rd_d    = rd_q;
        data_d  = data_q;
        if (Flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push_s) begin
                rd_d[tail_q]   = In_Rd;
                data_d[tail_q] = In_Data;
                tail_d         = tail_q + 1'b1;
            end else begin
                tail_d = tail_q;
            end
            if (pop_s) begin
                head_d = head_q + 1'b1;
            end else begin
                head_d = head_q;
            end
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            rd_q    <= '0;
            data_q  <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            rd_q    <= rd_d;
            data_q  <= data_d;
        end
    end

    // Busy scoreboard: decode every live entry's destination register.
    always_comb begin
        busy_s     = '0;
        busy_idx_s = '0;
        for (int k = 0; k < DEPTH; k++) begin
            busy_idx_s = head_q + PW'(k);
            if (CW'(k) < count_q) begin
                busy_s[rd_q[busy_idx_s]] = 1'b1;
            end else begin
                busy_s = busy_s;
            end
        end
    end

    fp_wb_fwd_match #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH)
    ) u_fwd1 (
        .ent_rd_i   (rd_q),
        .ent_data_i (data_q),
        .head_i     (head_q),
        .count_i    (count_q),
        .addr_i     (Addr1),
        .hit_o      (Fwd1_Hit),
        .data_o     (Fwd1_Data)
    );

    fp_wb_fwd_match #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH)
    ) u_fwd2 (
        .ent_rd_i   (rd_q),
        .ent_data_i (data_q),
        .head_i     (head_q),
        .count_i    (count_q),
        .addr_i     (Addr2),
        .hit_o      (Fwd2_Hit),
        .data_o     (Fwd2_Data)
    );

    assign In_Ready = ready_s;
    assign RF_WE    = pop_s;
    assign RF_W     = empty_s ? '0 : rd_q[head_q];
    assign RF_Din   = empty_s ? '0 : data_q[head_q];
    assign Busy     = busy_s;
    assign Count    = count_q;

endmodule

// File: tb/tb_fp_wb_buffer.sv
// Directed scenarios plus a randomized run checked against a queue-based model of the buffer.
module tb_fp_wb_buffer;
    import fp_pkg::*;

    localparam int AW = FP_ADDR_WIDTH;
    localparam int DW = FP_DATA_WIDTH;
    localparam int D  = FP_WB_DEPTH;
    localparam int CW = $clog2(D) + 1;

    logic            Clk = 1'b0;
    logic            Rst_n;
    logic            In_Valid, In_Ready, Flush, Drain_En, RF_WE;
    logic [AW-1:0]   In_Rd, RF_W, Addr1, Addr2;
    logic [DW-1:0]   In_Data, RF_Din, Fwd1_Data, Fwd2_Data;
    logic            Fwd1_Hit, Fwd2_Hit;
    logic [2**AW-1:0] Busy;
    logic [CW-1:0]   Count;

    int errors = 0;
    int checks = 0;
    fp_entry_t model_q[$];

    fp_wb_buffer dut (
        .Clk(Clk), .Rst_n(Rst_n), .In_Valid(In_Valid), .In_Ready(In_Ready), .In_Rd(In_Rd),
        .In_Data(In_Data), .Flush(Flush), .Drain_En(Drain_En), .RF_WE(RF_WE), .RF_W(RF_W),
        .RF_Din(RF_Din), .Addr1(Addr1), .Addr2(Addr2), .Fwd1_Hit(Fwd1_Hit), .Fwd2_Hit(Fwd2_Hit),
        .Fwd1_Data(Fwd1_Data), .Fwd2_Data(Fwd2_Data), .Busy(Busy), .Count(Count)
    );

    always #5 Clk = ~Clk;

    task automatic next_cycle();
        @(posedge Clk);
        @(negedge Clk);
    endtask

    task automatic push_one(input logic [AW-1:0] rd, input logic [DW-1:0] data);
        In_Valid = 1'b1; In_Rd = rd; In_Data = data;
        next_cycle();
        In_Valid = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        checks++; if (Count !== '0)   begin errors++; $display("FAIL reset_count: got %0d want 0", Count); end
        checks++; if (In_Ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", In_Ready); end
        checks++; if (RF_WE !== 1'b0) begin errors++; $display("FAIL reset_we: got %b want 0", RF_WE); end
        checks++; if (RF_W !== '0 || RF_Din !== '0) begin errors++; $display("FAIL reset_rf: got %h/%h want 0/0", RF_W, RF_Din); end
        checks++; if (Busy !== '0)    begin errors++; $display("FAIL reset_busy: got %h want 0", Busy); end
        @(negedge Clk);
        Rst_n = 1'b1;
    endtask

    task automatic test_single();
        Addr1 = 5'd3; Drain_En = 1'b0;
        In_Valid = 1'b1; In_Rd = 5'd3; In_Data = 32'h3F80_0000;
        #1;
        checks++; if (Fwd1_Hit !== 1'b0) begin errors++; $display("FAIL single_push_nofwd: got %b want 0", Fwd1_Hit); end
        checks++; if (RF_WE !== 1'b0) begin errors++; $display("FAIL single_no_passthru: got %b want 0", RF_WE); end
        next_cycle();
        In_Valid = 1'b0;
        #1;
        checks++; if (Count !== CW'(1)) begin errors++; $display("FAIL single_count: got %0d want 1", Count); end
        checks++; if (Busy[3] !== 1'b1) begin errors++; $display("FAIL single_busy3: got %b want 1", Busy[3]); end
        checks++; if (Fwd1_Hit !== 1'b1 || Fwd1_Data !== 32'h3F80_0000) begin errors++; $display("FAIL single_fwd: got %b/%h want 1/3f800000", Fwd1_Hit, Fwd1_Data); end
        Drain_En = 1'b1;
        #1;
        checks++; if (RF_WE !== 1'b1 || RF_W !== 5'd3 || RF_Din !== 32'h3F80_0000) begin errors++; $display("FAIL single_drain: got %b/%0d/%h want 1/3/3f800000", RF_WE, RF_W, RF_Din); end
        checks++; if (Fwd1_Hit !== 1'b1) begin errors++; $display("FAIL single_head_fwd: got %b want 1", Fwd1_Hit); end
        next_cycle();
        #1;
        checks++; if (Count !== '0 || Busy !== '0) begin errors++; $display("FAIL single_empty: got %0d/%h want 0/0", Count, Busy); end
        checks++; if (RF_WE !== 1'b0 || RF_W !== '0) begin errors++; $display("FAIL single_empty_rf: got %b/%0d want 0/0", RF_WE, RF_W); end
        Drain_En = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [AW-1:0] exp_rd [3];
        logic [DW-1:0] exp_d  [3];
        exp_rd[0] = 5'd3; exp_rd[1] = 5'd4; exp_rd[2] = 5'd6;
        exp_d[0] = 32'h102; exp_d[1] = 32'h103; exp_d[2] = 32'h55;
        Drain_En = 1'b0;
        for (int i = 0; i < 4; i++) push_one(AW'(i + 1), DW'(32'h100 + i));
        #1;
        checks++; if (Count !== CW'(4) || In_Ready !== 1'b0) begin errors++; $display("FAIL full: got %0d/%b want 4/0", Count, In_Ready); end
        In_Valid = 1'b1; In_Rd = 5'd6; In_Data = 32'h55;
        next_cycle();
        #1;
        checks++; if (Count !== CW'(4)) begin errors++; $display("FAIL full_reject: got %0d want 4", Count); end
        Drain_En = 1'b1;
        #1;
        checks++; if (RF_WE !== 1'b1 || RF_W !== 5'd1 || In_Ready !== 1'b0) begin errors++; $display("FAIL full_drain: got %b/%0d/%b want 1/1/0", RF_WE, RF_W, In_Ready); end
        next_cycle();
        #1;
        checks++; if (Count !== CW'(3) || In_Ready !== 1'b1 || RF_W !== 5'd2) begin errors++; $display("FAIL after_pop1: got %0d/%b/%0d want 3/1/2", Count, In_Ready, RF_W); end
        next_cycle();
        In_Valid = 1'b0;
        #1;
        checks++; if (Count !== CW'(3)) begin errors++; $display("FAIL push_pop_count: got %0d want 3", Count); end
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (RF_WE !== 1'b1 || RF_W !== exp_rd[i] || RF_Din !== exp_d[i]) begin errors++; $display("FAIL order_%0d: got %b/%0d/%h want 1/%0d/%h", i, RF_WE, RF_W, RF_Din, exp_rd[i], exp_d[i]); end
            next_cycle();
        end
        #1;
        checks++; if (Count !== '0) begin errors++; $display("FAIL drained: got %0d want 0", Count); end
        Drain_En = 1'b0;
    endtask

    task automatic test_youngest();
        Addr2 = 5'd5; Drain_En = 1'b0;
        push_one(5'd5, 32'h1);
        push_one(5'd5, 32'h2);
        #1;
        checks++; if (Fwd2_Hit !== 1'b1 || Fwd2_Data !== 32'h2) begin errors++; $display("FAIL young_fwd: got %b/%h want 1/2", Fwd2_Hit, Fwd2_Data); end
        Drain_En = 1'b1;
        next_cycle();
        #1;
        checks++; if (Fwd2_Data !== 32'h2 || Count !== CW'(1)) begin errors++; $display("FAIL young_after_pop: got %h/%0d want 2/1", Fwd2_Data, Count); end
        next_cycle();
        #1;
        checks++; if (Fwd2_Hit !== 1'b0 || Fwd2_Data !== '0) begin errors++; $display("FAIL young_gone: got %b/%h want 0/0", Fwd2_Hit, Fwd2_Data); end
        Drain_En = 1'b0;
    endtask

    task automatic test_rd_zero();
        Drain_En = 1'b1; Addr1 = 5'd0;
        In_Valid = 1'b1; In_Rd = 5'd0; In_Data = 32'hDEAD_BEEF;
        #1;
        checks++; if (In_Ready !== 1'b1) begin errors++; $display("FAIL rd0_ready: got %b want 1", In_Ready); end
        next_cycle();
        In_Valid = 1'b0;
        #1;
        checks++; if (Count !== '0 || RF_WE !== 1'b0 || Fwd1_Hit !== 1'b0) begin errors++; $display("FAIL rd0_dropped: got %0d/%b/%b want 0/0/0", Count, RF_WE, Fwd1_Hit); end
        Drain_En = 1'b0;
    endtask

    task automatic test_flush();
        Drain_En = 1'b0;
        push_one(5'd7, 32'h7);
        push_one(5'd8, 32'h8);
        push_one(5'd9, 32'h9);
        Flush = 1'b1; Drain_En = 1'b1; In_Valid = 1'b1; In_Rd = 5'd10; In_Data = 32'hA;
        #1;
        checks++; if (RF_WE !== 1'b0 || Count !== CW'(3)) begin errors++; $display("FAIL flush_we: got %b/%0d want 0/3", RF_WE, Count); end
        next_cycle();
        Flush = 1'b0; Drain_En = 1'b0; In_Valid = 1'b0;
        #1;
        checks++; if (Count !== '0 || Busy !== '0) begin errors++; $display("FAIL flush_clear: got %0d/%h want 0/0", Count, Busy); end
    endtask

    task automatic test_async_reset();
        Drain_En = 1'b0;
        push_one(5'd11, 32'hAAAA);
        push_one(5'd12, 32'hBBBB);
        Addr1 = 5'd11; Drain_En = 1'b1;
        #2 Rst_n = 1'b0;
        #1;
        checks++; if (Count !== '0 || Busy !== '0 || In_Ready !== 1'b1) begin errors++; $display("FAIL areset_state: got %0d/%h/%b want 0/0/1", Count, Busy, In_Ready); end
        checks++; if (RF_WE !== 1'b0 || RF_W !== '0 || RF_Din !== '0 || Fwd1_Hit !== 1'b0) begin errors++; $display("FAIL areset_outs: got %b/%0d/%h/%b want 0/0/0/0", RF_WE, RF_W, RF_Din, Fwd1_Hit); end
        #1 Rst_n = 1'b1;
        Drain_En = 1'b0; In_Valid = 1'b1; In_Rd = 5'd13; In_Data = 32'hCCCC;
        next_cycle();
        In_Valid = 1'b0;
        #1;
        checks++; if (Count !== CW'(1) || RF_W !== 5'd13 || RF_Din !== 32'hCCCC) begin errors++; $display("FAIL areset_push: got %0d/%0d/%h want 1/13/cccc", Count, RF_W, RF_Din); end
        Flush = 1'b1;
        next_cycle();
        Flush = 1'b0;
    endtask

    task automatic test_random();
        logic             e_ready, e_we, e_h1, e_h2;
        logic [AW-1:0]    e_w;
        logic [DW-1:0]    e_din, e_d1, e_d2;
        logic [2**AW-1:0] e_busy;
        fp_entry_t        ent;
        model_q.delete();
        for (int c = 0; c < 400; c++) begin
            In_Valid = ($urandom_range(9) < 7);
            In_Rd    = AW'($urandom_range(7));
            In_Data  = DW'($urandom);
            Flush    = ($urandom_range(19) == 0);
            Drain_En = ($urandom_range(1) == 1);
            Addr1    = AW'($urandom_range(7));
            Addr2    = AW'($urandom_range(7));
            #1;
            e_ready = (model_q.size() != D);
            e_we    = (model_q.size() != 0) && Drain_En && !Flush;
            e_w     = (model_q.size() != 0) ? model_q[0].rd : '0;
            e_din   = (model_q.size() != 0) ? model_q[0].data : '0;
            e_busy  = '0; e_h1 = 1'b0; e_h2 = 1'b0; e_d1 = '0; e_d2 = '0;
            foreach (model_q[i]) e_busy[model_q[i].rd] = 1'b1;
            for (int i = model_q.size() - 1; i >= 0; i--) begin
                if (!e_h1 && Addr1 != 0 && model_q[i].rd == Addr1) begin e_h1 = 1'b1; e_d1 = model_q[i].data; end
                if (!e_h2 && Addr2 != 0 && model_q[i].rd == Addr2) begin e_h2 = 1'b1; e_d2 = model_q[i].data; end
            end
            checks++; if (Count !== CW'(model_q.size())) begin errors++; $display("FAIL rnd_count c=%0d: got %0d want %0d", c, Count, model_q.size()); end
            checks++; if (In_Ready !== e_ready) begin errors++; $display("FAIL rnd_ready c=%0d: got %b want %b", c, In_Ready, e_ready); end
            checks++; if (RF_WE !== e_we) begin errors++; $display("FAIL rnd_we c=%0d: got %b want %b", c, RF_WE, e_we); end
            checks++; if (RF_W !== e_w || RF_Din !== e_din) begin errors++; $display("FAIL rnd_head c=%0d: got %0d/%h want %0d/%h", c, RF_W, RF_Din, e_w, e_din); end
            checks++; if (Busy !== e_busy) begin errors++; $display("FAIL rnd_busy c=%0d: got %h want %h", c, Busy, e_busy); end
            checks++; if (Fwd1_Hit !== e_h1 || Fwd1_Data !== e_d1) begin errors++; $display("FAIL rnd_fwd1 c=%0d: got %b/%h want %b/%h", c, Fwd1_Hit, Fwd1_Data, e_h1, e_d1); end
            checks++; if (Fwd2_Hit !== e_h2 || Fwd2_Data !== e_d2) begin errors++; $display("FAIL rnd_fwd2 c=%0d: got %b/%h want %b/%h", c, Fwd2_Hit, Fwd2_Data, e_h2, e_d2); end
            @(posedge Clk);
            if (Flush) begin
                model_q.delete();
            end else begin
                if (e_we) void'(model_q.pop_front());
                if (In_Valid && e_ready && In_Rd != 0) begin
                    ent.rd = In_Rd; ent.data = In_Data;
                    model_q.push_back(ent);
                end
            end
            @(negedge Clk);
        end
        In_Valid = 1'b0; Flush = 1'b0; Drain_En = 1'b0;
    endtask

    initial begin
        Rst_n = 1'b0; In_Valid = 1'b0; In_Rd = '0; In_Data = '0; Flush = 1'b0;
        Drain_En = 1'b0; Addr1 = '0; Addr2 = '0;
        test_reset();
        test_single();
        test_backpressure();
        test_youngest();
        test_rd_zero();
        test_flush();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fp_wb_buffer.md
FP_WB_BUFFER -- requirements
Module: fp_wb_buffer

Interface
REQ-001 Parameter DATA_WIDTH, default 32: width of FP result data.
REQ-002 Parameter ADDR_WIDTH, default 5: FP register address width.
REQ-003 Parameter DEPTH, default 4: queue entries; a power of two, at least 2.
REQ-004 Clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 Rst_n  input  1  reset, asynchronous and active-low.
REQ-006 In_Valid  input  1  producer (FPU) presents a result this cycle.
REQ-007 In_Ready  output  1  buffer can accept a result this cycle.
REQ-008 In_Rd  input  ADDR_WIDTH  destination FP register of the result.
REQ-009 In_Data  input  DATA_WIDTH  result value.
REQ-010 Flush  input  1  discard all queued results (pipeline squash).
REQ-011 Drain_En  input  1  FP regfile write port is available this cycle.
REQ-012 RF_WE  output  1  write enable to the FP regfile.
REQ-013 RF_W  output  ADDR_WIDTH  write address to the FP regfile.
REQ-014 RF_Din  output  DATA_WIDTH  write data to the FP regfile.
REQ-015 Addr1, Addr2  input  ADDR_WIDTH each  source addresses being read from the regfile.
REQ-016 Fwd1_Hit, Fwd2_Hit  output  1 each  a queued entry targets Addr1 / Addr2.
REQ-017 Fwd1_Data, Fwd2_Data  output  DATA_WIDTH each  youngest matching queued data; 0 when there is no hit.
REQ-018 Busy  output  2**ADDR_WIDTH  bit r set iff some queued entry targets register r.
REQ-019 Count  output  clog2(DEPTH)+1  number of queued entries.

Function
REQ-020 The queue shall be an in-order circular FIFO with head/tail pointers that wrap modulo DEPTH.
REQ-021 In_Ready shall equal (Count != DEPTH); it shall not depend on Drain_En, so a full buffer accepts nothing even in a cycle where it drains.
REQ-022 A push occurs when In_Valid && In_Ready && !Flush && In_Rd != 0; the entry {In_Rd, In_Data} is written at the tail.
REQ-023 A result with In_Rd == 0 shall be accepted (handshake completes) and discarded, with no entry written.
REQ-024 RF_WE shall equal (Count != 0) && Drain_En && !Flush; RF_W and RF_Din shall show the head entry combinationally, and both shall be 0 when the buffer is empty.
REQ-025 A pop occurs when RF_WE is 1; the head advances on that clock edge.
REQ-026 A simultaneous push and pop shall leave Count unchanged; Count shall never exceed DEPTH or underflow.
REQ-027 Flush shall clear the pointers and Count on the next edge and override both push and pop in that cycle.
REQ-028 Latency: an accepted result shall appear on RF_WE/RF_W/RF_Din no earlier than the cycle after acceptance; there is no same-cycle pass-through.
REQ-029 Forwarding on each read port shall be combinational over the valid entries only, excluding the entry being pushed this cycle.
REQ-030 When several valid entries match a read port, the youngest (closest to the tail) shall win.
REQ-031 Address 0 shall never hit.
REQ-032 The head entry being written this cycle shall still hit, because the regfile updates only at the edge.
REQ-033 Busy shall be the OR-decode of valid entry addresses and shall clear in the cycle after the last matching entry pops.

Reset
REQ-034 While Rst_n is low, the buffer shall hold the following values, asynchronously:
- Count = 0, both pointers = 0, Busy = 0;
- RF_WE = 0, RF_W = 0, RF_Din = 0;
- Fwd hits = 0;
- In_Ready = 1.
REQ-035 Reset asserted mid-operation shall drop all queued entries; entry data storage need not be cleared.
REQ-036 The first push shall be possible on the first rising edge after Rst_n deasserts.

Structure
REQ-037 DATA_WIDTH, ADDR_WIDTH, DEPTH and the entry record {rd, data} shall live in the shared package fp_pkg, which is reused by the FP regfile and the FPU.
REQ-038 One sub-module, fp_wb_fwd_match, shall be instantiated once per read port; it implements youngest-match priority selection from the entry array, the head index and Count.

Verification
REQ-039 Push f3=0x3F800000 with Drain_En=0, then raise Drain_En -> the cycle after acceptance shows Busy[3]=1 and Fwd1_Hit=1 (Addr1=3); when Drain_En=1, RF_WE=1, RF_W=3 and RF_Din=0x3F800000; one cycle later Count=0 and Busy=0.
REQ-040 Push 4 results with Drain_En=0 -> In_Ready=0 and a fifth In_Valid is not accepted; then set Drain_En=1 with In_Valid held -> pops occur in order, and the fifth result is accepted in the cycle after the first pop.
REQ-041 Push f5=0x1 then f5=0x2 with Addr2=5 -> Fwd2_Data=0x2; after one pop Fwd2_Data is still 0x2; after both pops Fwd2_Hit=0.
REQ-042 Push In_Rd=0 -> the handshake completes, Count stays 0 and RF_WE is never asserted.
REQ-043 Queue 3 entries, then assert Flush with In_Valid=1 and Drain_En=1 in the same cycle -> RF_WE=0 that cycle, and next cycle Count=0 and Busy=0.
REQ-044 Pulse Rst_n low between clock edges with 2 entries queued -> outputs reach their reset values immediately, and the first push after deassertion is accepted.
